// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register between decode and execute.
//
// Captures decoded fields plus register-file read data and presents them to
// EX and the operand-forwarding logic. A load sitting in this register cannot
// forward to the instruction right behind it, so that pair gets exactly one
// bubble. Also handles branch/exception flush and EX back-pressure.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   flush_i             kill the ID instruction and the held instruction
//   in_valid_i/in_ready_o  decode handshake
//   in_*_i              decoded fields and operand data from ID
//   out_ready_i/out_valid_o  EX handshake
//   out_*_o             registered copies of the in_* fields
//   load_use_stall_o    a load-use bubble is being inserted this cycle
//
// Optional build macro ID_EX_PERF_COUNTERS_EN adds bubble_count_o and
// stall_count_o (32-bit, wrapping).
module id_ex_stage #(
  parameter int         XLEN        = 32,
  parameter logic [6:0] LOAD_OPCODE = 7'b0000011
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [XLEN-1:0] in_pc_i,
  input  logic [4:0]      in_rs1_i,
  input  logic [4:0]      in_rs2_i,
  input  logic [4:0]      in_rd_i,
  input  logic [6:0]      in_opcode_i,
  input  logic [2:0]      in_funct3_i,
  input  logic [6:0]      in_funct7_i,
  input  logic [XLEN-1:0] in_rs1_data_i,
  input  logic [XLEN-1:0] in_rs2_data_i,
  input  logic [XLEN-1:0] in_imm_i,
  input  logic            out_ready_i,
  output logic            out_valid_o,
  output logic [XLEN-1:0] out_pc_o,
  output logic [4:0]      out_rs1_o,
  output logic [4:0]      out_rs2_o,
  output logic [4:0]      out_rd_o,
  output logic [6:0]      out_opcode_o,
  output logic [2:0]      out_funct3_o,
  output logic [6:0]      out_funct7_o,
  output logic [XLEN-1:0] out_rs1_data_o,
  output logic [XLEN-1:0] out_rs2_data_o,
  output logic [XLEN-1:0] out_imm_o,
  output logic            load_use_stall_o
`ifdef ID_EX_PERF_COUNTERS_EN
  ,
  output logic [31:0]     bubble_count_o,
  output logic [31:0]     stall_count_o
`endif
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
  } idex_t;

  idex_t data_q, data_d, in_data;
  logic  valid_q, valid_d;
  logic  advance, hazard;

  assign in_data = '{pc: in_pc_i, rs1: in_rs1_i, rs2: in_rs2_i, rd: in_rd_i,
                     opcode: in_opcode_i, funct3: in_funct3_i, funct7: in_funct7_i,
                     rs1_data: in_rs1_data_i, rs2_data: in_rs2_data_i, imm: in_imm_i};

  // Register empty or being consumed by EX this cycle.
  assign advance = out_ready_i | ~valid_q;

  // Both sources compared regardless of format: conservative, never misses.
  assign hazard = in_valid_i & valid_q & (data_q.opcode == LOAD_OPCODE) &
                  (data_q.rd != 5'd0) &
                  ((data_q.rd == in_rs1_i) | (data_q.rd == in_rs2_i));

  assign load_use_stall_o = hazard & advance & ~flush_i;
  assign in_ready_o       = advance & ~hazard & ~flush_i;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush_i) begin
      valid_d       = 1'b0;
      data_d.rd     = '0;
      data_d.opcode = '0;
    end else if (!advance) begin
      // stall: hold everything, EX forwarding supplies newer operands
    end else if (hazard) begin
      valid_d       = 1'b0;
      data_d.rd     = '0;
      data_d.opcode = '0;
    end else if (in_valid_i) begin
      valid_d = 1'b1;
      data_d  = in_data;
    end else begin
      // Bubbles carry rd=0/opcode=0 so forwarding never matches them.
      valid_d       = 1'b0;
      data_d.rd     = '0;
      data_d.opcode = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid_o    = valid_q;
  assign out_pc_o       = data_q.pc;
  assign out_rs1_o      = data_q.rs1;
  assign out_rs2_o      = data_q.rs2;
  assign out_rd_o       = data_q.rd;
  assign out_opcode_o   = data_q.opcode;
  assign out_funct3_o   = data_q.funct3;
  assign out_funct7_o   = data_q.funct7;
  assign out_rs1_data_o = data_q.rs1_data;
  assign out_rs2_data_o = data_q.rs2_data;
  assign out_imm_o      = data_q.imm;

`ifdef ID_EX_PERF_COUNTERS_EN
  logic [31:0] bubble_count_q, bubble_count_d;
  logic [31:0] stall_count_q,  stall_count_d;

  always_comb begin
    bubble_count_d = bubble_count_q + {31'd0, load_use_stall_o};
    stall_count_d  = stall_count_q + {31'd0, valid_q & ~out_ready_i & ~flush_i};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bubble_count_q <= '0;
      stall_count_q  <= '0;
    end else begin
      bubble_count_q <= bubble_count_d;
      stall_count_q  <= stall_count_d;
    end
  end

  assign bubble_count_o = bubble_count_q;
  assign stall_count_o  = stall_count_q;
`endif

endmodule
